// File: rtl/ecc_168_rd_err_collect.sv
// ecc_168_rd_err_collect
// Read-path stage behind the 168-bit ECC checker. Corrected words pass through
// a 2-entry skid buffer. Uncorrectable words (dbit or checker fault) are tagged
// as poisoned. Error counters, first-error capture and sticky interrupts are
// updated only for words that are actually accepted.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both high. Once out_vld is high, out_data and out_poison
// stay stable until out_rdy is seen. in_rdy and out_vld come straight from
// registers, so neither depends combinationally on the other side.
module ecc_168_rd_err_collect #(
  parameter int DATA_WIDTH  = 168,
  parameter int ADDR_WIDTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int SBIT_THRESH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sbit,
  input  logic                  in_dbit,
  input  logic                  in_fault,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_poison,
  input  logic                  clr,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic                  err_cap_vld,
  output logic [ADDR_WIDTH-1:0] err_cap_addr,
  output logic [1:0]            err_cap_type,
  output logic                  irq_sbit,
  output logic                  irq_dbit,
  output logic                  irq_fault
);

  // Skid buffer occupancy: ONE means only the output register holds a word,
  // FULL means the skid register holds the next word behind it.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam logic [1:0] CAP_SBIT  = 2'b01;
  localparam logic [1:0] CAP_DBIT  = 2'b10;
  localparam logic [1:0] CAP_FAULT = 2'b11;

  localparam logic [CNT_WIDTH-1:0] SBIT_THRESH_C = CNT_WIDTH'(SBIT_THRESH);

  skid_state_e           state_q;
  logic                  in_rdy_q;
  logic                  out_vld_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_poison_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic                  skid_poison_q;

  logic [CNT_WIDTH-1:0]  sbit_cnt_q,  sbit_cnt_d;
  logic [CNT_WIDTH-1:0]  dbit_cnt_q,  dbit_cnt_d;
  logic [CNT_WIDTH-1:0]  fault_cnt_q, fault_cnt_d;
  logic                  cap_vld_q,   cap_vld_d;
  logic [ADDR_WIDTH-1:0] cap_addr_q,  cap_addr_d;
  logic [1:0]            cap_type_q,  cap_type_d;
  logic                  irq_sbit_q,  irq_sbit_d;
  logic                  irq_dbit_q,  irq_dbit_d;
  logic                  irq_fault_q, irq_fault_d;

  logic accept;
  logic drain;
  logic in_poison;
  logic any_err;

  assign accept    = in_vld & in_rdy_q;
  assign drain     = out_vld_q & out_rdy;
  assign in_poison = in_dbit | in_fault;
  assign any_err   = in_sbit | in_dbit | in_fault;

  // Counter step that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (v != {CNT_WIDTH{1'b1}})) begin
      return v + CNT_WIDTH'(1);
    end
    return v;
  endfunction

  // Skid buffer FSM with registered in_rdy/out_vld and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      in_rdy_q      <= 1'b1;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_poison_q  <= 1'b0;
      skid_data_q   <= '0;
      skid_poison_q <= 1'b0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_data_q   <= in_data;
            out_poison_q <= in_poison;
            out_vld_q    <= 1'b1;
            state_q      <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            // Output word leaves as the new one arrives: stay at one entry.
            out_data_q   <= in_data;
            out_poison_q <= in_poison;
          end else if (accept) begin
            // Output is stalled: park the new word in the skid register.
            skid_data_q   <= in_data;
            skid_poison_q <= in_poison;
            in_rdy_q      <= 1'b0;
            state_q       <= ST_FULL;
          end else if (drain) begin
            out_vld_q <= 1'b0;
            state_q   <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_rdy is low here, so only a drain can happen.
          if (drain) begin
            out_data_q   <= skid_data_q;
            out_poison_q <= skid_poison_q;
            in_rdy_q     <= 1'b1;
            state_q      <= ST_ONE;
          end
        end
        default: begin
          state_q   <= ST_EMPTY;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  // Error bookkeeping: clr zeroes first, then the accepted word is applied.
  always_comb begin
    logic [CNT_WIDTH-1:0] sbit_base;
    logic [CNT_WIDTH-1:0] dbit_base;
    logic [CNT_WIDTH-1:0] fault_base;

    sbit_base  = clr ? '0 : sbit_cnt_q;
    dbit_base  = clr ? '0 : dbit_cnt_q;
    fault_base = clr ? '0 : fault_cnt_q;

    sbit_cnt_d  = sat_inc(sbit_base,  accept & in_sbit);
    dbit_cnt_d  = sat_inc(dbit_base,  accept & in_dbit);
    fault_cnt_d = sat_inc(fault_base, accept & in_fault);

    cap_vld_d  = clr ? 1'b0 : cap_vld_q;
    cap_addr_d = clr ? '0   : cap_addr_q;
    cap_type_d = clr ? 2'b00 : cap_type_q;
    if (!cap_vld_d && accept && any_err) begin
      cap_vld_d  = 1'b1;
      cap_addr_d = in_addr;
      if (in_fault) begin
        cap_type_d = CAP_FAULT;
      end else if (in_dbit) begin
        cap_type_d = CAP_DBIT;
      end else begin
        cap_type_d = CAP_SBIT;
      end
    end

    // irq_sbit follows the counter value being written this edge.
    irq_sbit_d  = (clr ? 1'b0 : irq_sbit_q)  | (sbit_cnt_d >= SBIT_THRESH_C);
    irq_dbit_d  = (clr ? 1'b0 : irq_dbit_q)  | (accept & in_dbit);
    irq_fault_d = (clr ? 1'b0 : irq_fault_q) | (accept & in_fault);
  end

  // Error bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      fault_cnt_q <= '0;
      cap_vld_q   <= 1'b0;
      cap_addr_q  <= '0;
      cap_type_q  <= 2'b00;
      irq_sbit_q  <= 1'b0;
      irq_dbit_q  <= 1'b0;
      irq_fault_q <= 1'b0;
    end else begin
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      cap_vld_q   <= cap_vld_d;
      cap_addr_q  <= cap_addr_d;
      cap_type_q  <= cap_type_d;
      irq_sbit_q  <= irq_sbit_d;
      irq_dbit_q  <= irq_dbit_d;
      irq_fault_q <= irq_fault_d;
    end
  end

  assign in_rdy       = in_rdy_q;
  assign out_vld      = out_vld_q;
  assign out_data     = out_data_q;
  assign out_poison   = out_poison_q;
  assign sbit_cnt     = sbit_cnt_q;
  assign dbit_cnt     = dbit_cnt_q;
  assign fault_cnt    = fault_cnt_q;
  assign err_cap_vld  = cap_vld_q;
  assign err_cap_addr = cap_addr_q;
  assign err_cap_type = cap_type_q;
  assign irq_sbit     = irq_sbit_q;
  assign irq_dbit     = irq_dbit_q;
  assign irq_fault    = irq_fault_q;

endmodule

// File: tb/tb_ecc_168_rd_err_collect.sv
// Directed bench for ecc_168_rd_err_collect. A second instance with 4-bit
// counters shares the stimulus so counter saturation is reachable quickly.
module tb_ecc_168_rd_err_collect;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic         in_vld = 1'b0;
  logic [7:0]   in_addr = '0;
  logic [167:0] in_data = '0;
  logic         in_sbit = 1'b0;
  logic         in_dbit = 1'b0;
  logic         in_fault = 1'b0;
  logic         out_rdy = 1'b0;
  logic         clr = 1'b0;

  logic         in_rdy, out_vld, out_poison;
  logic [167:0] out_data;
  logic [15:0]  sbit_cnt, dbit_cnt, fault_cnt;
  logic         err_cap_vld;
  logic [7:0]   err_cap_addr;
  logic [1:0]   err_cap_type;
  logic         irq_sbit, irq_dbit, irq_fault;

  logic         s_in_rdy, s_out_vld, s_out_poison;
  logic [167:0] s_out_data;
  logic [3:0]   s_sbit_cnt, s_dbit_cnt, s_fault_cnt;
  logic         s_cap_vld;
  logic [7:0]   s_cap_addr;
  logic [1:0]   s_cap_type;
  logic         s_irq_sbit, s_irq_dbit, s_irq_fault;

  int n_cmp = 0;
  int n_err = 0;

  ecc_168_rd_err_collect dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_addr(in_addr), .in_data(in_data),
    .in_sbit(in_sbit), .in_dbit(in_dbit), .in_fault(in_fault),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data), .out_poison(out_poison),
    .clr(clr),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .fault_cnt(fault_cnt),
    .err_cap_vld(err_cap_vld), .err_cap_addr(err_cap_addr), .err_cap_type(err_cap_type),
    .irq_sbit(irq_sbit), .irq_dbit(irq_dbit), .irq_fault(irq_fault)
  );

  ecc_168_rd_err_collect #(.CNT_WIDTH(4), .SBIT_THRESH(3)) dut_small (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_rdy(s_in_rdy), .in_addr(in_addr), .in_data(in_data),
    .in_sbit(in_sbit), .in_dbit(in_dbit), .in_fault(in_fault),
    .out_vld(s_out_vld), .out_rdy(out_rdy), .out_data(s_out_data), .out_poison(s_out_poison),
    .clr(clr),
    .sbit_cnt(s_sbit_cnt), .dbit_cnt(s_dbit_cnt), .fault_cnt(s_fault_cnt),
    .err_cap_vld(s_cap_vld), .err_cap_addr(s_cap_addr), .err_cap_type(s_cap_type),
    .irq_sbit(s_irq_sbit), .irq_dbit(s_irq_dbit), .irq_fault(s_irq_fault)
  );

  // ---------------- driver tasks ----------------
  function automatic logic [167:0] pat(input int i);
    logic [27:0] t;
    t = 28'hA5C3000 + 28'(i);
    return {6{t}};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input logic [7:0] a, input logic [167:0] d,
                            input logic s, input logic db, input logic f);
    in_vld   = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_sbit  = s;
    in_dbit  = db;
    in_fault = f;
  endtask

  task automatic idle();
    in_vld   = 1'b0;
    in_sbit  = 1'b0;
    in_dbit  = 1'b0;
    in_fault = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    clr = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    out_rdy = 1'b0;
    do_reset();
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL reset_out_vld: got %b want 0", out_vld); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== 48'd0) begin n_err++; $display("FAIL reset_counters: got %h want 0", {sbit_cnt, dbit_cnt, fault_cnt}); end
    n_cmp++; if ({err_cap_vld, err_cap_addr, err_cap_type} !== 11'd0) begin n_err++; $display("FAIL reset_capture: got %h want 0", {err_cap_vld, err_cap_addr, err_cap_type}); end
    n_cmp++; if ({irq_sbit, irq_dbit, irq_fault, out_poison} !== 4'b0) begin n_err++; $display("FAIL reset_irqs: got %b want 0000", {irq_sbit, irq_dbit, irq_fault, out_poison}); end
  endtask

  task automatic test_stream();
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_word(8'(i), pat(i), 1'b0, 1'b0, 1'b0);
      step();
      n_cmp++; if (out_vld !== 1'b1) begin n_err++; $display("FAIL stream_vld[%0d]: got %b want 1", i, out_vld); end
      n_cmp++; if (out_data !== pat(i)) begin n_err++; $display("FAIL stream_data[%0d]: got %h want %h", i, out_data, pat(i)); end
      n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL stream_in_rdy[%0d]: got %b want 1", i, in_rdy); end
    end
    idle();
    step();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b want 0", out_vld); end
    n_cmp++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== 48'd0) begin n_err++; $display("FAIL stream_counters: got %h want 0", {sbit_cnt, dbit_cnt, fault_cnt}); end
    n_cmp++; if ({irq_sbit, irq_dbit, irq_fault, err_cap_vld} !== 4'b0) begin n_err++; $display("FAIL stream_irqs: got %b want 0000", {irq_sbit, irq_dbit, irq_fault, err_cap_vld}); end
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    drive_word(8'h10, pat(16), 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_after_1: got %b want 1", in_rdy); end
    drive_word(8'h11, pat(17), 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_after_2: got %b want 0", in_rdy); end
    drive_word(8'h12, pat(18), 1'b0, 1'b0, 1'b0);
    step();
    n_cmp++; if (in_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rdy_stall: got %b want 0", in_rdy); end
    n_cmp++; if (out_vld !== 1'b1 || out_data !== pat(16)) begin n_err++; $display("FAIL bp_hold: got vld=%b data=%h want vld=1 data=%h", out_vld, out_data, pat(16)); end
    idle();
    out_rdy = 1'b1;
    step();
    n_cmp++; if (out_vld !== 1'b1 || out_data !== pat(17)) begin n_err++; $display("FAIL bp_second: got vld=%b data=%h want vld=1 data=%h", out_vld, out_data, pat(17)); end
    n_cmp++; if (in_rdy !== 1'b1) begin n_err++; $display("FAIL bp_rdy_return: got %b want 1", in_rdy); end
    step();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b want 0", out_vld); end
  endtask

  task automatic test_ignored_flags();
    out_rdy = 1'b0;
    drive_word(8'h20, pat(32), 1'b0, 1'b0, 1'b0);
    step();
    drive_word(8'h21, pat(33), 1'b0, 1'b0, 1'b0);
    step();
    // Offered while FULL: must be neither accepted nor counted.
    drive_word(8'h22, pat(34), 1'b1, 1'b0, 1'b1);
    step();
    n_cmp++; if ({sbit_cnt, fault_cnt} !== 32'd0 || err_cap_vld !== 1'b0) begin n_err++; $display("FAIL ign_not_ready: got sbit=%0d fault=%0d cap=%b want 0 0 0", sbit_cnt, fault_cnt, err_cap_vld); end
    // Flags with in_vld low must also be ignored.
    in_vld  = 1'b0;
    in_dbit = 1'b1;
    out_rdy = 1'b1;
    step();
    n_cmp++; if (out_data !== pat(33) || out_vld !== 1'b1) begin n_err++; $display("FAIL ign_order: got vld=%b data=%h want vld=1 data=%h", out_vld, out_data, pat(33)); end
    step();
    idle();
    n_cmp++; if (dbit_cnt !== 16'd0 || irq_dbit !== 1'b0) begin n_err++; $display("FAIL ign_no_vld: got dbit=%0d irq=%b want 0 0", dbit_cnt, irq_dbit); end
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL ign_drained: got %b want 0", out_vld); end
  endtask

  task automatic test_errors();
    out_rdy = 1'b1;
    drive_word(8'h05, pat(5), 1'b1, 1'b0, 1'b0);
    step();
    n_cmp++; if (out_poison !== 1'b0) begin n_err++; $display("FAIL err_sbit_poison: got %b want 0", out_poison); end
    n_cmp++; if (err_cap_vld !== 1'b1 || err_cap_addr !== 8'h05 || err_cap_type !== 2'b01) begin n_err++; $display("FAIL err_cap_first: got vld=%b addr=%h type=%b want 1 05 01", err_cap_vld, err_cap_addr, err_cap_type); end
    n_cmp++; if (sbit_cnt !== 16'd1) begin n_err++; $display("FAIL err_sbit_cnt: got %0d want 1", sbit_cnt); end
    drive_word(8'h09, pat(9), 1'b0, 1'b1, 1'b0);
    step();
    idle();
    n_cmp++; if (out_poison !== 1'b1 || out_data !== pat(9)) begin n_err++; $display("FAIL err_dbit_poison: got poison=%b data=%h want 1 %h", out_poison, out_data, pat(9)); end
    n_cmp++; if (err_cap_addr !== 8'h05 || err_cap_type !== 2'b01) begin n_err++; $display("FAIL err_cap_kept: got addr=%h type=%b want 05 01", err_cap_addr, err_cap_type); end
    n_cmp++; if (dbit_cnt !== 16'd1 || irq_dbit !== 1'b1) begin n_err++; $display("FAIL err_dbit_irq: got cnt=%0d irq=%b want 1 1", dbit_cnt, irq_dbit); end
    n_cmp++; if (irq_sbit !== 1'b0 || irq_fault !== 1'b0) begin n_err++; $display("FAIL err_other_irqs: got sbit=%b fault=%b want 0 0", irq_sbit, irq_fault); end
    step();
  endtask

  task automatic test_clr_with_word();
    out_rdy = 1'b1;
    clr = 1'b1;
    drive_word(8'h33, pat(51), 1'b1, 1'b0, 1'b0);
    step();
    clr = 1'b0;
    idle();
    n_cmp++; if (sbit_cnt !== 16'd1 || dbit_cnt !== 16'd0) begin n_err++; $display("FAIL clrw_counts: got sbit=%0d dbit=%0d want 1 0", sbit_cnt, dbit_cnt); end
    n_cmp++; if (err_cap_vld !== 1'b1 || err_cap_addr !== 8'h33 || err_cap_type !== 2'b01) begin n_err++; $display("FAIL clrw_capture: got vld=%b addr=%h type=%b want 1 33 01", err_cap_vld, err_cap_addr, err_cap_type); end
    n_cmp++; if (irq_dbit !== 1'b0) begin n_err++; $display("FAIL clrw_irq_dbit: got %b want 0", irq_dbit); end
    step();
  endtask

  task automatic test_clr_plain();
    clr = 1'b1;
    step();
    clr = 1'b0;
    n_cmp++; if (sbit_cnt !== 16'd0 || err_cap_vld !== 1'b0 || err_cap_addr !== 8'h00 || err_cap_type !== 2'b00) begin n_err++; $display("FAIL clr_plain: got sbit=%0d cap=%b addr=%h type=%b want all 0", sbit_cnt, err_cap_vld, err_cap_addr, err_cap_type); end
  endtask

  task automatic test_sbit_thresh();
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      drive_word(8'(8'h60 + i), pat(96 + i), 1'b1, 1'b0, 1'b0);
      step();
      if (i == 15) begin
        n_cmp++; if (sbit_cnt !== 16'd15 || irq_sbit !== 1'b0) begin n_err++; $display("FAIL thresh_15: got cnt=%0d irq=%b want 15 0", sbit_cnt, irq_sbit); end
      end
      if (i == 16) begin
        n_cmp++; if (sbit_cnt !== 16'd16 || irq_sbit !== 1'b1) begin n_err++; $display("FAIL thresh_16: got cnt=%0d irq=%b want 16 1", sbit_cnt, irq_sbit); end
      end
    end
    idle();
    step();
    n_cmp++; if (irq_sbit !== 1'b1) begin n_err++; $display("FAIL thresh_sticky: got %b want 1", irq_sbit); end
  endtask

  task automatic test_saturation();
    do_reset();
    out_rdy = 1'b1;
    drive_word(8'h40, pat(64), 1'b1, 1'b1, 1'b1);
    step();
    n_cmp++; if ({sbit_cnt, dbit_cnt, fault_cnt} !== {16'd1, 16'd1, 16'd1}) begin n_err++; $display("FAIL sat_multi_count: got %h want 000100010001", {sbit_cnt, dbit_cnt, fault_cnt}); end
    n_cmp++; if (err_cap_type !== 2'b11 || err_cap_addr !== 8'h40 || out_poison !== 1'b1) begin n_err++; $display("FAIL sat_prio: got type=%b addr=%h poison=%b want 11 40 1", err_cap_type, err_cap_addr, out_poison); end
    for (int i = 1; i < 20; i++) begin
      drive_word(8'(8'h40 + i), pat(64 + i), 1'b0, 1'b0, 1'b1);
      step();
    end
    idle();
    step();
    n_cmp++; if (s_fault_cnt !== 4'd15) begin n_err++; $display("FAIL sat_small_fault: got %0d want 15", s_fault_cnt); end
    n_cmp++; if (fault_cnt !== 16'd20) begin n_err++; $display("FAIL sat_wide_fault: got %0d want 20", fault_cnt); end
    n_cmp++; if (s_irq_fault !== 1'b1 || s_cap_type !== 2'b11 || s_cap_addr !== 8'h40) begin n_err++; $display("FAIL sat_small_cap: got irq=%b type=%b addr=%h want 1 11 40", s_irq_fault, s_cap_type, s_cap_addr); end
    n_cmp++; if (s_dbit_cnt !== 4'd1 || s_sbit_cnt !== 4'd1) begin n_err++; $display("FAIL sat_small_other: got dbit=%0d sbit=%0d want 1 1", s_dbit_cnt, s_sbit_cnt); end
  endtask

  task automatic test_rst_mid();
    out_rdy = 1'b0;
    drive_word(8'h70, pat(112), 1'b0, 1'b0, 1'b0);
    step();
    drive_word(8'h71, pat(113), 1'b0, 1'b0, 1'b0);
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin n_err++; $display("FAIL rst_mid: got vld=%b rdy=%b want 0 1", out_vld, in_rdy); end
    out_rdy = 1'b1;
    step();
    n_cmp++; if (out_vld !== 1'b0) begin n_err++; $display("FAIL rst_mid_after: got %b want 0", out_vld); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ignored_flags();
    test_errors();
    test_clr_with_word();
    test_clr_plain();
    test_sbit_thresh();
    test_saturation();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
